// File: rtl/quidditch_pkg.sv
// Shared types and helpers for the quidditch scoreboard scoring controller.
//   SCORE_W        width of a team score register
//   game_state_t   game FSM states (IDLE, PLAY, OVER)
//   score_event_t  scoring event applied through the shared adder
//   TEAM_A/TEAM_B  bit index of each team in the request/ack vectors
//   WIN_*          encodings of the winner output
package quidditch_pkg;

    localparam int SCORE_W = 14;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } game_state_t;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_PENALTY,
        EV_GOAL,
        EV_SNITCH
    } score_event_t;

    localparam int TEAM_A = 0;
    localparam int TEAM_B = 1;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    // Within one team the snitch outranks a goal, which outranks a penalty.
    function automatic score_event_t pick_event(input logic snitch,
                                                input logic goal,
                                                input logic penalty);
        score_event_t ev;
        ev = EV_NONE;
        if (snitch)
            ev = EV_SNITCH;
        else if (goal)
            ev = EV_GOAL;
        else if (penalty)
            ev = EV_PENALTY;
        return ev;
    endfunction

    function automatic logic [1:0] win_code(input logic [SCORE_W-1:0] score_a,
                                            input logic [SCORE_W-1:0] score_b);
        logic [1:0] code;
        code = WIN_TIE;
        if (score_a > score_b)
            code = WIN_A;
        else if (score_b > score_a)
            code = WIN_B;
        return code;
    endfunction

endpackage

// File: rtl/score_alu.sv
// Combinational saturating score adder/subtractor shared by both teams.
//   i_score  current score of the granted team
//   i_event  event to apply (EV_NONE passes the score through)
//   o_score  next score: adds clamp at MAX_SCORE, the penalty floors at 0
module score_alu
    import quidditch_pkg::*;
#(
    parameter logic [SCORE_W-1:0] MAX_SCORE   = 14'd9999,
    parameter logic [SCORE_W-1:0] GOAL_PTS    = 14'd10,
    parameter logic [SCORE_W-1:0] PENALTY_PTS = 14'd5,
    parameter logic [SCORE_W-1:0] SNITCH_PTS  = 14'd150
) (
    input  logic [SCORE_W-1:0] i_score,
    input  score_event_t       i_event,
    output logic [SCORE_W-1:0] o_score
);

    logic [SCORE_W-1:0] w_add_pts;
    logic [SCORE_W:0]   w_sum;

    always_comb begin
        w_add_pts = '0;
        if (i_event == EV_GOAL)
            w_add_pts = GOAL_PTS;
        else if (i_event == EV_SNITCH)
            w_add_pts = SNITCH_PTS;
    end

    // One extra bit so a sum past the 14-bit range is still seen as too large.
    assign w_sum = {1'b0, i_score} + {1'b0, w_add_pts};

    always_comb begin
        o_score = i_score;
        case (i_event)
            EV_GOAL, EV_SNITCH: begin
                if (w_sum > {1'b0, MAX_SCORE})
                    o_score = MAX_SCORE;
                else
                    o_score = w_sum[SCORE_W-1:0];
            end
            EV_PENALTY: begin
                if (i_score < PENALTY_PTS)
                    o_score = '0;
                else
                    o_score = i_score - PENALTY_PTS;
            end
            default: o_score = i_score;
        endcase
    end

endmodule

// File: rtl/quidditch_score_ctrl.sv
// Game-level scoring controller: game FSM, match timer, round-robin
// arbitration between the two teams and the two score registers.
//   clk, rst_n                  clock; asynchronous active-low reset
//   start                       pulse, starts a game from IDLE or OVER
//   goal_req/penalty_req/
//   snitch_req [1:0]            level requests per team (bit0 A, bit1 B)
//   ack [1:0]                   one-cycle pulse when a team's request applied
//   score_a/score_b [13:0]      team scores
//   playing/game_over           FSM in PLAY / OVER
//   winner [1:0]                01 A, 10 B, 11 tie; valid in OVER
module quidditch_score_ctrl
    import quidditch_pkg::*;
#(
    parameter logic [SCORE_W-1:0] MAX_SCORE   = 14'd9999,
    parameter logic [SCORE_W-1:0] GOAL_PTS    = 14'd10,
    parameter logic [SCORE_W-1:0] PENALTY_PTS = 14'd5,
    parameter logic [SCORE_W-1:0] SNITCH_PTS  = 14'd150,
    parameter logic [31:0]        GAME_CYCLES = 32'd60000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         goal_req,
    input  logic [1:0]         penalty_req,
    input  logic [1:0]         snitch_req,
    output logic [1:0]         ack,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic               playing,
    output logic               game_over,
    output logic [1:0]         winner
);

    game_state_t        r_state;
    game_state_t        w_state_next;
    logic [31:0]        r_timer;
    logic [SCORE_W-1:0] r_score_a;
    logic [SCORE_W-1:0] r_score_b;
    logic [1:0]         r_ack;
    logic               r_last_grant;
    logic [1:0]         r_winner;

    score_event_t       w_event [2];
    logic [1:0]         w_pending;
    logic               w_grant_valid;
    logic               w_grant_team;
    logic [1:0]         w_ack_next;
    score_event_t       w_alu_event;
    logic [SCORE_W-1:0] w_alu_in;
    logic [SCORE_W-1:0] w_alu_out;
    logic [SCORE_W-1:0] w_score_a_next;
    logic [SCORE_W-1:0] w_score_b_next;
    logic               w_timer_done;
    logic               w_snitch_grant;
    logic               w_enter_play;
    logic               w_enter_over;

    // A team whose ack is high this cycle has already been served for the
    // request it is still holding, so it sits out one cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_team
            assign w_event[gi]   = pick_event(snitch_req[gi], goal_req[gi], penalty_req[gi]);
            assign w_pending[gi] = (r_state == PLAY) && !r_ack[gi] && (w_event[gi] != EV_NONE);
        end
    endgenerate

    // Round-robin: on contention the team not granted last wins; otherwise
    // the lone requester (B if only bit1 is pending, A otherwise).
    assign w_grant_valid = |w_pending;
    assign w_grant_team  = (&w_pending) ? ~r_last_grant : w_pending[TEAM_B];

    always_comb begin
        w_ack_next = 2'b00;
        if (w_grant_valid)
            w_ack_next[w_grant_team] = 1'b1;
    end

    assign w_alu_in    = w_grant_team ? r_score_b : r_score_a;
    assign w_alu_event = w_grant_valid ? w_event[w_grant_team] : EV_NONE;

    score_alu #(
        .MAX_SCORE   (MAX_SCORE),
        .GOAL_PTS    (GOAL_PTS),
        .PENALTY_PTS (PENALTY_PTS),
        .SNITCH_PTS  (SNITCH_PTS)
    ) u_score_alu (
        .i_score (w_alu_in),
        .i_event (w_alu_event),
        .o_score (w_alu_out)
    );

    assign w_score_a_next = (w_grant_valid && (w_grant_team == 1'b0)) ? w_alu_out : r_score_a;
    assign w_score_b_next = (w_grant_valid && (w_grant_team == 1'b1)) ? w_alu_out : r_score_b;

    assign w_timer_done   = (r_timer == GAME_CYCLES - 32'd1);
    assign w_snitch_grant = w_grant_valid && (w_alu_event == EV_SNITCH);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (start) w_state_next = PLAY;
            PLAY: if (w_snitch_grant || w_timer_done) w_state_next = OVER;
            OVER: if (start) w_state_next = PLAY;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_enter_play = (r_state != PLAY) && (w_state_next == PLAY);
    assign w_enter_over = (r_state == PLAY) && (w_state_next == OVER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_score_a    <= '0;
            r_score_b    <= '0;
            r_ack        <= 2'b00;
            r_last_grant <= 1'b1;
            r_winner     <= WIN_NONE;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_ack_next;
            if (w_grant_valid)
                r_last_grant <= w_grant_team;

            if (w_enter_play) begin
                r_timer   <= '0;
                r_score_a <= '0;
                r_score_b <= '0;
                r_winner  <= WIN_NONE;
            end else begin
                if (r_state == PLAY)
                    r_timer <= r_timer + 32'd1;
                r_score_a <= w_score_a_next;
                r_score_b <= w_score_b_next;
                // Judge on the post-update scores so a final snitch counts.
                if (w_enter_over)
                    r_winner <= win_code(w_score_a_next, w_score_b_next);
            end
        end
    end

    assign ack       = r_ack;
    assign score_a   = r_score_a;
    assign score_b   = r_score_b;
    assign playing   = (r_state == PLAY);
    assign game_over = (r_state == OVER);
    assign winner    = r_winner;

endmodule

// File: tb/tb_quidditch_score_ctrl.sv
// Directed bench for quidditch_score_ctrl: reset, arbitration order,
// priority and penalty floor, saturation, snitch/timer game end, and an
// asynchronous reset in the middle of a game.
module tb_quidditch_score_ctrl;

    localparam logic [31:0] GAME_LEN = 32'd4000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  goal_req;
    logic [1:0]  penalty_req;
    logic [1:0]  snitch_req;
    logic [1:0]  ack;
    logic [13:0] score_a;
    logic [13:0] score_b;
    logic        playing;
    logic        game_over;
    logic [1:0]  winner;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int start_cyc;
    int guard;

    always #5 clk = ~clk;

    quidditch_score_ctrl #(
        .GAME_CYCLES (GAME_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .goal_req    (goal_req),
        .penalty_req (penalty_req),
        .snitch_req  (snitch_req),
        .ack         (ack),
        .score_a     (score_a),
        .score_b     (score_b),
        .playing     (playing),
        .game_over   (game_over),
        .winner      (winner)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-18s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_ack, input int e_a,
                           input int e_b, input logic e_play, input logic e_over,
                           input logic [1:0] e_win);
        chk({tag, ".ack"},  32'(ack),       32'(e_ack));
        chk({tag, ".sa"},   32'(score_a),   32'(e_a));
        chk({tag, ".sb"},   32'(score_b),   32'(e_b));
        chk({tag, ".play"}, 32'(playing),   32'(e_play));
        chk({tag, ".over"}, 32'(game_over), 32'(e_over));
        chk({tag, ".win"},  32'(winner),    32'(e_win));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        goal_req = 2'b00; penalty_req = 2'b00; snitch_req = 2'b00;
        tick(); tick();
        chk_all("in_reset", 2'b00, 0, 0, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b1;
        tick();

        // IDLE ignores requests
        goal_req = 2'b01; tick();
        chk_all("idle_req", 2'b00, 0, 0, 1'b0, 1'b0, 2'b00);
        goal_req = 2'b00;

        // ---- game 1: priority, penalty floor, snitch end ----
        start = 1'b1; tick(); start = 1'b0;
        chk_all("start1", 2'b00, 0, 0, 1'b1, 1'b0, 2'b00);

        goal_req = 2'b01; penalty_req = 2'b01; tick();
        chk_all("prio_goal", 2'b01, 10, 0, 1'b1, 1'b0, 2'b00);
        goal_req = 2'b00;
        tick(); chk("mask_cycle.ack", 32'(ack), 32'd0);
        tick(); chk_all("pen1", 2'b01, 5, 0, 1'b1, 1'b0, 2'b00);
        tick(); chk("mask2.ack", 32'(ack), 32'd0);
        tick(); chk_all("pen2", 2'b01, 0, 0, 1'b1, 1'b0, 2'b00);
        tick();
        tick(); chk_all("pen_floor", 2'b01, 0, 0, 1'b1, 1'b0, 2'b00);
        penalty_req = 2'b00;
        tick(); chk("pen_idle.ack", 32'(ack), 32'd0);

        goal_req = 2'b01; tick(); chk("g1.sa", 32'(score_a), 32'd10);
        tick(); tick(); chk("g2.sa", 32'(score_a), 32'd20);
        goal_req = 2'b00; tick();

        snitch_req = 2'b10; tick(); snitch_req = 2'b00;
        chk_all("snitch_b", 2'b10, 20, 150, 1'b0, 1'b1, 2'b10);
        goal_req = 2'b11; tick(); goal_req = 2'b00;
        chk_all("over_req", 2'b00, 20, 150, 1'b0, 1'b1, 2'b10);

        // ---- game 2: simultaneous goals, start ignored, timer end ----
        start = 1'b1; tick(); start = 1'b0; start_cyc = cyc;
        chk_all("start2", 2'b00, 0, 0, 1'b1, 1'b0, 2'b00);
        goal_req = 2'b11; tick();
        chk_all("sim_a_first", 2'b01, 10, 0, 1'b1, 1'b0, 2'b00);
        goal_req = 2'b10; tick();
        chk_all("sim_b_next", 2'b10, 10, 10, 1'b1, 1'b0, 2'b00);
        goal_req = 2'b00;
        start = 1'b1; tick(); start = 1'b0;
        chk_all("start_in_play", 2'b00, 10, 10, 1'b1, 1'b0, 2'b00);

        guard = 0;
        while (!game_over && guard < 6000) begin
            tick();
            guard++;
        end
        chk("timer_len", 32'(cyc - start_cyc), GAME_LEN);
        chk_all("timer_end", 2'b00, 10, 10, 1'b0, 1'b1, 2'b11);
        goal_req = 2'b11; snitch_req = 2'b01; tick();
        goal_req = 2'b00; snitch_req = 2'b00;
        chk_all("after_timer", 2'b00, 10, 10, 1'b0, 1'b1, 2'b11);

        // ---- game 3: round-robin repeat, saturation ----
        start = 1'b1; tick(); start = 1'b0;
        chk_all("start3_clear", 2'b00, 0, 0, 1'b1, 1'b0, 2'b00);
        goal_req = 2'b01; tick(); goal_req = 2'b00;
        chk("solo_a.sa", 32'(score_a), 32'd10);
        tick();
        goal_req = 2'b11; tick();
        chk_all("rep_b_first", 2'b10, 10, 10, 1'b1, 1'b0, 2'b00);
        goal_req = 2'b01; tick();
        chk_all("rep_a_next", 2'b01, 20, 10, 1'b1, 1'b0, 2'b00);
        goal_req = 2'b00; tick();
        penalty_req = 2'b01; tick(); penalty_req = 2'b00;
        chk("pen15.sa", 32'(score_a), 32'd15);
        tick();
        for (int i = 0; i < 998; i++) begin
            goal_req = 2'b01; tick();
            goal_req = 2'b00; tick();
        end
        chk("climb.sa", 32'(score_a), 32'd9995);
        goal_req = 2'b01; tick(); goal_req = 2'b00;
        chk_all("sat_goal", 2'b01, 9999, 10, 1'b1, 1'b0, 2'b00);
        tick();
        snitch_req = 2'b01; tick(); snitch_req = 2'b00;
        chk_all("sat_snitch", 2'b01, 9999, 10, 1'b0, 1'b1, 2'b01);

        // ---- game 4: reset mid-game ----
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            goal_req = 2'b01; tick(); goal_req = 2'b00; tick();
        end
        for (int i = 0; i < 3; i++) begin
            goal_req = 2'b10; tick(); goal_req = 2'b00; tick();
        end
        chk_all("pre_reset", 2'b00, 40, 30, 1'b1, 1'b0, 2'b00);
        goal_req = 2'b11; penalty_req = 2'b11; snitch_req = 2'b11;
        #1 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 2'b00, 0, 0, 1'b0, 1'b0, 2'b00);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk_all("post_rst_idle", 2'b00, 0, 0, 1'b0, 1'b0, 2'b00);
        goal_req = 2'b00; penalty_req = 2'b00; snitch_req = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
